// File: rtl/mc_pkg.sv
// Shared constants and state encoding for the program-memory loader slice.
package mc_pkg;

    // Default instruction word width and program memory address width.
    localparam int MC_INST_W = 12;
    localparam int MC_ADDR_W = 8;

    // Loader session states. CHECK and ERR are reachable only in the
    // checksum build; the encoding is shared so debug views stay stable.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    // True in the states where a new session may be started.
    function automatic logic start_allowed(input state_e s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
    endfunction

endpackage

// File: rtl/pmem_load_ctrl.sv
// Program memory load controller.
// Streams prog_len instruction words from a valid/ready source into program
// memory, then pulses core_clr once so the core restarts from a clean state.
// Optional build macro LOAD_CHECKSUM_EN adds a trailer word compared against
// the mod-2^INST_W sum of the loaded words (CHECK/ERR states, err flag).
//
// Handshake: a source word moves only on a rising edge where in_valid and
// in_ready are both high; in_ready depends on state only, never on in_valid,
// and in_valid may be raised or dropped freely between transfers.
module pmem_load_ctrl
    import mc_pkg::*;
#(
    parameter int INST_W = MC_INST_W,
    parameter int ADDR_W = MC_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] prog_len,
    input  logic              in_valid,
    input  logic [INST_W-1:0] in_data,
    output logic              in_ready,
    output logic              pmem_le,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [INST_W-1:0] pmem_data,
    output logic              busy,
    output logic              load_done,
    output logic              core_clr,
    output logic              err,
    output state_e            state_dbg
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              le_q, le_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [INST_W-1:0] data_q, data_d;
    logic              clr_q, clr_d;
`ifdef LOAD_CHECKSUM_EN
    logic [INST_W-1:0] sum_q, sum_d;
`endif

    logic start_ok;
    logic xfer;
    logic last_word;

    // A start is honoured only outside an active session.
    assign start_ok  = start && start_allowed(state_q);
    assign in_ready  = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign xfer      = in_valid && in_ready;
    assign last_word = (cnt_q == (len_q - ADDR_W'(1)));

    // State and datapath registers; reset discards any partial session.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            le_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            clr_q   <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            le_q    <= le_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            clr_q   <= clr_d;
`ifdef LOAD_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Next-state, write-port and core-clear decisions.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        le_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        clr_d   = 1'b0;
`ifdef LOAD_CHECKSUM_EN
        sum_d   = sum_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                // abort is meaningless here and deliberately not looked at.
                if (start_ok) begin
                    if (prog_len == '0) begin
                        // Empty program: nothing to load, restart the core.
                        state_d = ST_DONE;
                        clr_d   = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                        len_d   = prog_len;
                        cnt_d   = '0;
`ifdef LOAD_CHECKSUM_EN
                        sum_d   = '0;
`endif
                    end
                end
            end

            ST_LOAD: begin
                // abort wins over a word arriving in the same cycle.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    le_d   = 1'b1;
                    addr_d = cnt_q;
                    data_d = in_data;
                    cnt_d  = cnt_q + ADDR_W'(1);
`ifdef LOAD_CHECKSUM_EN
                    sum_d  = sum_q + in_data;
`endif
                    if (last_word) begin
`ifdef LOAD_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_DONE;
                        clr_d   = 1'b1;
`endif
                    end
                end
            end

`ifdef LOAD_CHECKSUM_EN
            ST_CHECK: begin
                // The trailer is compared, never written to program memory.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    if (in_data == sum_q) begin
                        state_d = ST_DONE;
                        clr_d   = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pmem_le   = le_q;
    assign pmem_addr = addr_q;
    assign pmem_data = data_q;
    assign busy      = in_ready;
    assign load_done = (state_q == ST_DONE);
    assign core_clr  = clr_q;
    assign state_dbg = state_q;
`ifdef LOAD_CHECKSUM_EN
    assign err       = (state_q == ST_ERR);
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_load_ctrl.sv
// Directed bench for pmem_load_ctrl: hand-computed expectations checked with
// immediate assertions after each rising edge.
module tb_pmem_load_ctrl;
    import mc_pkg::*;

    localparam int INST_W = 12;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] prog_len;
    logic              in_valid;
    logic [INST_W-1:0] in_data;
    logic              in_ready;
    logic              pmem_le;
    logic [ADDR_W-1:0] pmem_addr;
    logic [INST_W-1:0] pmem_data;
    logic              busy;
    logic              load_done;
    logic              core_clr;
    logic              err;
    state_e            state_dbg;

    int total = 0;
    int bad   = 0;

    pmem_load_ctrl #(.INST_W(INST_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .prog_len  (prog_len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .pmem_le   (pmem_le),
        .pmem_addr (pmem_addr),
        .pmem_data (pmem_data),
        .busy      (busy),
        .load_done (load_done),
        .core_clr  (core_clr),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // Clock and reset block
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison point.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the write port in one call.
    task automatic chk_wr(input string tag, input logic le, input logic [ADDR_W-1:0] a,
                          input logic [INST_W-1:0] d);
        chk({tag, "_le"}, 32'(pmem_le), 32'(le));
        if (le) begin
            chk({tag, "_addr"}, 32'(pmem_addr), 32'(a));
            chk({tag, "_data"}, 32'(pmem_data), 32'(d));
        end
    endtask

    // Driver: present a start for one edge.
    task automatic drv_start(input logic [ADDR_W-1:0] len);
        start    = 1'b1;
        prog_len = len;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        prog_len = '0;
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        tick();
        // Reset state
        chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_le", 32'(pmem_le), 0);
        chk("rst_addr", 32'(pmem_addr), 0);
        chk("rst_data", 32'(pmem_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(load_done), 0);
        chk("rst_clr", 32'(core_clr), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        tick();
        // abort in IDLE changes nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_state", 32'(state_dbg), 32'(ST_IDLE));

        // Three words back-to-back
        drv_start(8'd3);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_ready", 32'(in_ready), 1);
        chk("t1_done0", 32'(load_done), 0);
        chk_wr("t1_nowr", 1'b0, '0, '0);
        in_valid = 1'b1;
        in_data  = 12'h101;
        tick();
        chk_wr("t1_w0", 1'b1, 8'd0, 12'h101);
        chk("t1_clr_w0", 32'(core_clr), 0);
        in_data = 12'h202;
        tick();
        chk_wr("t1_w1", 1'b1, 8'd1, 12'h202);
        in_data = 12'h303;
        tick();
        in_valid = 1'b0;
`ifdef LOAD_CHECKSUM_EN
        chk_wr("t1_w2", 1'b1, 8'd2, 12'h303);
        chk("t1_check", 32'(state_dbg), 32'(ST_CHECK));
        in_valid = 1'b1;
        in_data  = 12'h606;
        tick();
        in_valid = 1'b0;
        chk("t1_trailer_nowr", 32'(pmem_le), 0);
`else
        chk_wr("t1_w2", 1'b1, 8'd2, 12'h303);
`endif
        chk("t1_clr", 32'(core_clr), 1);
        chk("t1_done", 32'(load_done), 1);
        chk("t1_busy_end", 32'(busy), 0);
        tick();
        chk("t1_clr_once", 32'(core_clr), 0);
        chk("t1_done_hold", 32'(load_done), 1);
        chk("t1_le_off", 32'(pmem_le), 0);
        // abort in DONE ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("done_abort", 32'(load_done), 1);

        // Two words with a 3-cycle gap; a start mid-load is ignored
        drv_start(8'd2);
        in_valid = 1'b1;
        in_data  = 12'h0AA;
        tick();
        chk_wr("t2_w0", 1'b1, 8'd0, 12'h0AA);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                start    = 1'b1;
                prog_len = 8'd5;
            end
            tick();
            start = 1'b0;
            chk("t2_gap_le", 32'(pmem_le), 0);
            chk("t2_gap_busy", 32'(busy), 1);
        end
        in_valid = 1'b1;
        in_data  = 12'h0BB;
        tick();
        in_valid = 1'b0;
        chk_wr("t2_w1", 1'b1, 8'd1, 12'h0BB);
`ifdef LOAD_CHECKSUM_EN
        in_valid = 1'b1;
        in_data  = 12'h165;
        tick();
        in_valid = 1'b0;
`endif
        chk("t2_done", 32'(load_done), 1);
        chk("t2_clr", 32'(core_clr), 1);

        // Abort after word 1 of 4; abort beats a same-cycle transfer
        drv_start(8'd4);
        in_valid = 1'b1;
        in_data  = 12'h011;
        tick();
        chk_wr("t3_w0", 1'b1, 8'd0, 12'h011);
        in_data = 12'h022;
        abort   = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("t3_state", 32'(state_dbg), 32'(ST_IDLE));
        chk("t3_le", 32'(pmem_le), 0);
        chk("t3_clr", 32'(core_clr), 0);
        chk("t3_done", 32'(load_done), 0);
        chk("t3_busy", 32'(busy), 0);
        tick();
        chk("t3_clr_late", 32'(core_clr), 0);
        drv_start(8'd1);
        in_valid = 1'b1;
        in_data  = 12'h777;
        tick();
        in_valid = 1'b0;
        chk_wr("t3_w_new", 1'b1, 8'd0, 12'h777);
`ifdef LOAD_CHECKSUM_EN
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
`endif
        chk("t3_new_done", 32'(load_done), 1);
        chk("t3_new_clr", 32'(core_clr), 1);

        // Empty program
        tick();
        drv_start(8'd0);
        chk("t4_state", 32'(state_dbg), 32'(ST_DONE));
        chk("t4_clr", 32'(core_clr), 1);
        chk("t4_le", 32'(pmem_le), 0);
        tick();
        chk("t4_clr_once", 32'(core_clr), 0);
        chk("t4_le2", 32'(pmem_le), 0);

`ifdef LOAD_CHECKSUM_EN
        // Checksum: 0xFFF + 0x002 = 0x001 mod 2^12
        drv_start(8'd2);
        in_valid = 1'b1;
        in_data  = 12'hFFF;
        tick();
        in_data = 12'h002;
        tick();
        in_data = 12'h001;
        tick();
        in_valid = 1'b0;
        chk("cs_ok_state", 32'(state_dbg), 32'(ST_DONE));
        chk("cs_ok_clr", 32'(core_clr), 1);
        chk("cs_ok_err", 32'(err), 0);
        drv_start(8'd2);
        in_valid = 1'b1;
        in_data  = 12'hFFF;
        tick();
        in_data = 12'h002;
        tick();
        in_data = 12'h000;
        tick();
        in_valid = 1'b0;
        chk("cs_bad_state", 32'(state_dbg), 32'(ST_ERR));
        chk("cs_bad_err", 32'(err), 1);
        chk("cs_bad_clr", 32'(core_clr), 0);
        chk("cs_bad_le", 32'(pmem_le), 0);
        tick();
        chk("cs_err_hold", 32'(err), 1);
        drv_start(8'd0);
        chk("cs_err_clear", 32'(err), 0);
`endif

        // Asynchronous reset between edges mid-LOAD
        drv_start(8'd3);
        in_valid = 1'b1;
        in_data  = 12'h123;
        tick();
        chk_wr("t5_w0", 1'b1, 8'd0, 12'h123);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_state", 32'(state_dbg), 32'(ST_IDLE));
        chk("t5_ready", 32'(in_ready), 0);
        chk("t5_le", 32'(pmem_le), 0);
        chk("t5_addr", 32'(pmem_addr), 0);
        chk("t5_data", 32'(pmem_data), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(load_done), 0);
        chk("t5_clr", 32'(core_clr), 0);
        chk("t5_err", 32'(err), 0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("t5_post_clr", 32'(core_clr), 0);
        chk("t5_post_state", 32'(state_dbg), 32'(ST_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
